// File: rtl/ryu_motion_ctrl.sv
// ryu_motion_ctrl: per-frame walk/jump sprite motion for Ryu; optional crouch when RYU_CROUCH_EN is defined
module ryu_motion_ctrl #(
  parameter int SPR_W      = 120,
  parameter int GROUND_Y   = 300,
  parameter int START_X    = 100,
  parameter int X_MAX      = 640,
  parameter int WALK_SPEED = 4,
  parameter int JUMP_V0    = 12,
  parameter int FALL_VMAX  = 12
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       vs,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
`ifdef RYU_CROUCH_EN
  input  logic       key_crouch,
  output logic       crouching,
`endif
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       facing_left,
  output logic       airborne,
  output logic       frame_tick
);
  typedef enum logic [1:0] {GROUND = 2'd0, RISING = 2'd1, FALLING = 2'd2} state_t;

  localparam logic signed [10:0] WS   = 11'(WALK_SPEED);
  localparam logic signed [10:0] XLIM = 11'(X_MAX - SPR_W);
  localparam logic [9:0]         GY   = 10'(GROUND_Y);
  localparam logic [7:0]         JV   = 8'(JUMP_V0);
  localparam logic [7:0]         FV   = 8'(FALL_VMAX);

  if (GROUND_Y < JUMP_V0 * (JUMP_V0 + 1) / 2) begin : g_apex_check
    $error("ryu_motion_ctrl: GROUND_Y too small for the jump apex");
  end

  state_t              state, state_n;
  logic [7:0]          vel, vel_n, v_fall;
  logic [9:0]          x_n, y_n;
  logic [10:0]         y_fall;
  logic signed [10:0]  x_s;
  logic                vs_q, tick, go_r, go_l, facing_n, crouch;

  assign tick = vs_q & ~vs;

`ifdef RYU_CROUCH_EN
  assign crouch = key_crouch && state == GROUND;
`else
  assign crouch = 1'b0;
`endif

  // next position, facing, velocity and state for the coming frame tick
  always_comb begin
    go_r     = key_right & ~key_left;
    go_l     = key_left & ~key_right;
    x_s      = $signed({1'b0, RyuX}) + (crouch ? 11'sd0 : go_r ? WS : go_l ? -WS : 11'sd0);
    x_n      = x_s < 11'sd0 ? 10'd0 : x_s > XLIM ? 10'(XLIM) : x_s[9:0];
    facing_n = go_r ? 1'b0 : go_l ? 1'b1 : facing_left;
    v_fall   = vel >= FV ? FV : vel + 8'd1;
    y_fall   = {1'b0, RyuY} + {3'b0, v_fall};
    state_n  = state;
    vel_n    = vel;
    y_n      = RyuY;
    case (state)
      GROUND: begin
        state_n = key_jump && !crouch ? RISING : GROUND;
        vel_n   = key_jump && !crouch ? JV : 8'd0;
      end
      RISING: begin
        y_n     = RyuY - {2'b0, vel};
        vel_n   = vel - 8'd1;
        state_n = vel == 8'd1 ? FALLING : RISING;
      end
      FALLING: begin
        state_n = y_fall >= {1'b0, GY} ? GROUND : FALLING;
        vel_n   = y_fall >= {1'b0, GY} ? 8'd0 : v_fall;
        y_n     = y_fall >= {1'b0, GY} ? GY : y_fall[9:0];
      end
      default: begin
        state_n = GROUND;
        vel_n   = 8'd0;
        y_n     = GY;
      end
    endcase
  end

  // vsync edge tracking every cycle; all motion state commits only on the frame tick
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vs_q        <= 1'b1;
      frame_tick  <= 1'b0;
      state       <= GROUND;
      vel         <= 8'd0;
      RyuX        <= 10'(START_X);
      RyuY        <= GY;
      facing_left <= 1'b0;
      airborne    <= 1'b0;
`ifdef RYU_CROUCH_EN
      crouching   <= 1'b0;
`endif
    end else begin
      vs_q       <= vs;
      frame_tick <= tick;
      if (tick) begin
        state       <= state_n;
        vel         <= vel_n;
        RyuX        <= x_n;
        RyuY        <= y_n;
        facing_left <= facing_n;
        airborne    <= state_n != GROUND;
`ifdef RYU_CROUCH_EN
        crouching   <= crouch;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// tb_ryu_motion_ctrl: randomized frame stimulus against a signed-velocity motion model
module tb_ryu_motion_ctrl;
  logic       vga_clk = 1'b0, reset_n = 1'b0, vs = 1'b1;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0, key_crouch = 1'b0;
  logic [9:0] RyuX, RyuY;
  logic       facing_left, airborne, frame_tick;
`ifdef RYU_CROUCH_EN
  logic       crouching;
`endif
  int total = 0, bad = 0, ftc = 0, ymin = 1023;
  bit en = 1'b0;
  int mx = 100, my = 300, vy = 0;
  bit mf = 1'b0, mair = 1'b0, mtick = 1'b0, mcr = 1'b0, pv = 1'b1;

  always #5 vga_clk = ~vga_clk;

  ryu_motion_ctrl dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
`ifdef RYU_CROUCH_EN
    .key_crouch(key_crouch), .crouching(crouching),
`endif
    .RyuX(RyuX), .RyuY(RyuY), .facing_left(facing_left),
    .airborne(airborne), .frame_tick(frame_tick)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  // reference: upward motion is negative vy; one update per falling vsync edge
  always @(posedge vga_clk) begin : model
    bit r, l, cr;
    if (!reset_n) begin
      mx = 100; my = 300; vy = 0; mf = 0; mair = 0; mtick = 0; mcr = 0; pv = 1;
    end else begin
      mtick = pv && !vs;
      pv = vs;
      if (mtick) begin
        r = key_right && !key_left;
        l = key_left && !key_right;
`ifdef RYU_CROUCH_EN
        cr = key_crouch && !mair;
`else
        cr = 0;
`endif
        if (!cr && r) mx += 4;
        if (!cr && l) mx -= 4;
        if (mx < 0) mx = 0;
        if (mx > 520) mx = 520;
        if (r) mf = 0;
        if (l) mf = 1;
        if (!mair) begin
          if (key_jump && !cr) begin mair = 1; vy = -12; end
        end else if (vy < 0) begin
          my += vy; vy++;
        end else begin
          vy = (vy + 1 > 12) ? 12 : vy + 1;
          if (my + vy >= 300) begin my = 300; mair = 0; vy = 0; end
          else my += vy;
        end
        mcr = cr;
      end
    end
  end

  always @(negedge vga_clk) if (en) begin
    chk("x", RyuX, mx);
    chk("y", RyuY, my);
    chk("facing", facing_left, mf);
    chk("airborne", airborne, mair);
    chk("frame_tick", frame_tick, mtick);
`ifdef RYU_CROUCH_EN
    chk("crouching", crouching, mcr);
`endif
    if (frame_tick) ftc++;
    if (int'(RyuY) < ymin) ymin = int'(RyuY);
  end

  task automatic frame(input bit l, input bit r, input bit j, input bit c);
    key_left = l; key_right = r; key_jump = j; key_crouch = c; vs = 1'b0;
    @(negedge vga_clk);
    {key_left, key_right, key_jump, key_crouch} = 4'($urandom);
    repeat (2) @(negedge vga_clk);
    vs = 1'b1;
    {key_left, key_right, key_jump, key_crouch} = 4'($urandom);
    repeat (2) @(negedge vga_clk);
  endtask

  initial begin
    repeat (3) @(negedge vga_clk);
    en = 1'b1;
    reset_n = 1'b1;
    @(negedge vga_clk);
    chk("rst_x", RyuX, 100);
    chk("rst_y", RyuY, 300);
    chk("rst_air", airborne, 0);
    ftc = 0;
    repeat (3) frame(0, 0, 0, 0);
    chk("tick_count", ftc, 3);
    chk("idle_x", RyuX, 100);
    repeat (5) frame(0, 1, 0, 0);
    chk("walk_right_x", RyuX, 120);
    chk("walk_right_face", facing_left, 0);
    repeat (30) frame(1, 0, 0, 0);
    chk("clamp_left_x", RyuX, 0);
    chk("clamp_left_face", facing_left, 1);
    repeat (200) frame(0, 1, 0, 0);
    chk("clamp_right_x", RyuX, 520);
    repeat (3) frame(1, 1, 0, 0);
    chk("both_x", RyuX, 520);
    chk("both_face_r", facing_left, 0);
    frame(1, 0, 0, 0);
    repeat (2) frame(1, 1, 0, 0);
    chk("both_face_l", facing_left, 1);
    chk("both_x2", RyuX, 516);
    ymin = 1023;
    frame(0, 0, 1, 0);
    chk("jump_y0", RyuY, 300);
    chk("jump_air", airborne, 1);
    frame(0, 0, 0, 0);
    chk("jump_y1", RyuY, 288);
    frame(0, 0, 0, 0);
    chk("jump_y2", RyuY, 277);
    repeat (40) frame(0, 0, 0, 0);
    chk("apex", ymin, 222);
    chk("land_y", RyuY, 300);
    chk("land_air", airborne, 0);
    frame(0, 0, 1, 0);
    repeat (3) frame(0, 0, 0, 0);
    chk("rise_air", airborne, 1);
    reset_n = 1'b0;
    @(negedge vga_clk);
    chk("abort_y", RyuY, 300);
    chk("abort_air", airborne, 0);
    chk("abort_x", RyuX, 100);
    reset_n = 1'b1;
    @(negedge vga_clk);
`ifdef RYU_CROUCH_EN
    repeat (3) frame(0, 1, 1, 1);
    chk("crouch_on", crouching, 1);
    chk("crouch_x", RyuX, 100);
    chk("crouch_face", facing_left, 0);
    chk("crouch_air", airborne, 0);
    frame(0, 0, 0, 0);
    chk("crouch_off", crouching, 0);
`endif
    repeat (500) frame(1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ryu_motion_ctrl.md
Name: ryu_motion_ctrl

Overview:
- Upstream of the Ryu sprite renderers; produces sprite top-left RyuX/RyuY and facing select, once per video frame.
- Inputs: decoded keyboard move/jump flags and VGA vsync.
- Walk and jump FSM with gravity and screen-edge clamping.
- Outputs are registered and stable for the whole active frame; renderers consume them directly.

Parameters:
- SPR_W, 120, rendered sprite width in pixels (used for right-edge clamp)
- GROUND_Y, 300, RyuY while grounded (300+180=480 bottom of screen)
- START_X, 100, RyuX after reset
- X_MAX, 640, right screen limit; RyuX never exceeds X_MAX-SPR_W
- WALK_SPEED, 4, pixels per frame horizontal
- JUMP_V0, 12, initial upward velocity, pixels/frame
- FALL_VMAX, 12, falling velocity cap

Ports:
- vga_clk, in, 1, pixel clock; all state on posedge
- reset_n, in, 1, synchronous active-low reset
- vs, in, 1, VGA vertical sync, active low
- key_left, in, 1, left held
- key_right, in, 1, right held
- key_jump, in, 1, jump held
- RyuX, out, 10, sprite left X
- RyuY, out, 10, sprite top Y
- facing_left, out, 1, 1 = renderer selects left-facing sprite
- airborne, out, 1, 1 while RISING or FALLING
- frame_tick, out, 1, one-cycle pulse on the update cycle

Behaviour:
- Reset (reset_n=0 at posedge): RyuX=START_X, RyuY=GROUND_Y, facing_left=0, airborne=0, frame_tick=0, state=GROUND, vel=0, vs_q=1. Reset mid-jump aborts the jump immediately.
- Tick detect:
  - vs_q registers vs each cycle.
  - tick = vs_q & ~vs, the falling edge of vs.
  - Updates commit on the posedge where tick is true; frame_tick is high that same cycle only.
  - Latency: vs fall → new RyuX/RyuY visible 1 clock later.
- Key sampling: keys are sampled only on the tick cycle; changes between ticks have no effect.
- Horizontal, all states:
  - dir = right only: +WALK_SPEED.
  - dir = left only: -WALK_SPEED.
  - Both or neither: 0.
- Horizontal clamp, computed at 11-bit signed width:
  - Result < 0 → 0.
  - Result > X_MAX-SPR_W → X_MAX-SPR_W.
- Facing: right-only → facing_left=0; left-only → facing_left=1; otherwise unchanged.
- FSM:
  - GROUND: if key_jump → RISING, vel=JUMP_V0, RyuY unchanged this tick.
  - RISING: RyuY -= vel; vel -= 1. When the post-decrement vel==0 → FALLING.
  - FALLING: vel = min(vel+1, FALL_VMAX). If RyuY+vel >= GROUND_Y → RyuY=GROUND_Y, vel=0, GROUND; else RyuY += vel.
  - Holding key_jump through landing re-jumps on the next tick, not the landing tick.
- Apex: total rise = JUMP_V0(JUMP_V0+1)/2 = 78 px, giving min RyuY=222. RyuY never underflows; elaborate-time check GROUND_Y >= rise.
- airborne = (state != GROUND), registered with the positions.
- Unused encodings → GROUND next tick, RyuY=GROUND_Y.

Optional Feature:
- Macro: RYU_CROUCH_EN.
- Defined:
  - Adds input key_crouch (1 bit) and output crouching (1 bit, reset 0).
  - In GROUND with key_crouch sampled high: crouching=1, horizontal motion suppressed (facing still updates), jump ignored.
  - crouching forced 0 when airborne.
- Undefined: ports absent, no crouch logic.

Test Plan:
- Reset hold then release, no keys, 3 vs falls → RyuX=100, RyuY=300, facing_left=0, airborne=0; frame_tick exactly one cycle per vs fall.
- key_right held 5 frames → RyuX=120, facing_left=0; toggling key_right between vs edges has no effect.
- key_left held 30 frames from 100 → RyuX clamps at 0, facing_left=1.
- key_right held 200 frames → RyuX clamps at 520; left+right together → no move, facing unchanged.
- key_jump one frame:
  - RyuY sequence 300, 288, 277, … 222 at apex, then descends and lands exactly 300.
  - airborne high throughout; land tick lands exactly 300 with no overshoot.
- Reset asserted mid-RISING → next posedge RyuY=300, airborne=0, RyuX=100.
- With RYU_CROUCH_EN: crouch+right+jump held → crouching=1, RyuX unchanged, facing_left=0, no jump.
